line_consensus: RTL and testbench

Parametrised nonogram line solver, successor to the fixed 4x4 solver. It accepts one line header (a row or column index plus an option count) and then streams that line's candidate fill patterns. It intersects the surviving candidates to derive newly known cells and writes them into a MAX_SIZE x MAX_SIZE known/assigned board. It reports per line how many options survived and whether the line must go back to the option FIFO.

---
 rtl/line_consensus.sv | 179 +++++++++++++++++
 tb/tb_line_consensus.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_consensus.sv
// rtl/line_consensus.sv - nonogram line solver: intersects candidate fill patterns into a known/assigned board
// Define LINE_CONSENSUS_FILTER_EN to drop options that contradict already-known cells.
module line_consensus #(
  parameter int MAX_SIZE = 11,
  parameter int CNT_W    = 7,
  parameter int IDX_W    = $clog2(2*MAX_SIZE),
  parameter int DIM_W    = $clog2(MAX_SIZE+1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         started,
  input  logic [DIM_W-1:0]             num_rows,
  input  logic [DIM_W-1:0]             num_cols,
  input  logic                         line_valid,
  output logic                         line_ready,
  input  logic [IDX_W-1:0]             line_index,
  input  logic [CNT_W-1:0]             line_opt_cnt,
  input  logic                         opt_valid,
  output logic                         opt_ready,
  input  logic [MAX_SIZE-1:0]          option,
  output logic                         done_valid,
  output logic [IDX_W-1:0]             done_index,
  output logic [CNT_W-1:0]             new_options_amnt,
  output logic                         put_back_to_FIFO,
  output logic                         conflict,
  output logic [MAX_SIZE*MAX_SIZE-1:0] known,
  output logic [MAX_SIZE*MAX_SIZE-1:0] assigned,
  output logic                         solved
);
  localparam int CELLS = MAX_SIZE*MAX_SIZE;

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

  state_t               state_q;
  logic [DIM_W-1:0]     rows_q, cols_q;
  logic [IDX_W-1:0]     idx_q, done_index_q;
  logic [CNT_W-1:0]     rem_q, keep_q, amnt_q;
  logic [MAX_SIZE-1:0]  and_q, or_q;
  logic [CELLS-1:0]     known_q, assigned_q;
  logic                 solved_q, done_valid_q, put_back_q, conflict_q;

  logic                 is_row, in_range, consistent, line_open;
  logic [IDX_W:0]       line_lim;
  logic [IDX_W-1:0]     line_sel;
  logic [DIM_W-1:0]     len;
  logic [MAX_SIZE-1:0]  len_mask, line_known, line_newk;
  logic [CELLS-1:0]     known_d, assigned_d, active_mask;

  always_comb begin
    line_lim    = (IDX_W+1)'(rows_q) + (IDX_W+1)'(cols_q);
    is_row      = idx_q < IDX_W'(rows_q);
    in_range    = {1'b0, idx_q} < line_lim;
    line_sel    = is_row ? idx_q : idx_q - IDX_W'(rows_q);
    len         = is_row ? cols_q : rows_q;
    len_mask    = '0;
    line_known  = '0;
    active_mask = '0;
    for (int i = 0; i < MAX_SIZE; i++) len_mask[i] = DIM_W'(i) < len;
    for (int r = 0; r < MAX_SIZE; r++) begin
      for (int c = 0; c < MAX_SIZE; c++) begin
        active_mask[r*MAX_SIZE+c] = (DIM_W'(r) < rows_q) && (DIM_W'(c) < cols_q);
        if (is_row && IDX_W'(r) == line_sel)  line_known[c] = known_q[r*MAX_SIZE+c];
        if (!is_row && IDX_W'(c) == line_sel) line_known[r] = known_q[r*MAX_SIZE+c];
      end
    end
    // Cells every survivor agrees on, excluding cells that are already settled.
    line_newk  = (and_q | ~or_q) & len_mask & ~line_known;
    line_open  = |(len_mask & ~(line_known | line_newk));
    known_d    = known_q;
    assigned_d = assigned_q;
    for (int r = 0; r < MAX_SIZE; r++) begin
      for (int c = 0; c < MAX_SIZE; c++) begin
        if (is_row && IDX_W'(r) == line_sel && line_newk[c]) begin
          known_d[r*MAX_SIZE+c]    = 1'b1;
          assigned_d[r*MAX_SIZE+c] = and_q[c];
        end
        if (!is_row && IDX_W'(c) == line_sel && line_newk[r]) begin
          known_d[r*MAX_SIZE+c]    = 1'b1;
          assigned_d[r*MAX_SIZE+c] = and_q[r];
        end
      end
    end
  end

`ifdef LINE_CONSENSUS_FILTER_EN
  logic [MAX_SIZE-1:0] line_asg;
  always_comb begin
    line_asg = '0;
    for (int r = 0; r < MAX_SIZE; r++) begin
      for (int c = 0; c < MAX_SIZE; c++) begin
        if (is_row && IDX_W'(r) == line_sel)  line_asg[c] = assigned_q[r*MAX_SIZE+c];
        if (!is_row && IDX_W'(c) == line_sel) line_asg[r] = assigned_q[r*MAX_SIZE+c];
      end
    end
    consistent = ((option ^ line_asg) & line_known & len_mask) == '0;
  end
`else
  assign consistent = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rows_q       <= DIM_W'(MAX_SIZE);
      cols_q       <= DIM_W'(MAX_SIZE);
      idx_q        <= '0;
      rem_q        <= '0;
      keep_q       <= '0;
      and_q        <= '1;
      or_q         <= '0;
      known_q      <= '0;
      assigned_q   <= '0;
      solved_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_index_q <= '0;
      amnt_q       <= '0;
      put_back_q   <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      done_valid_q <= 1'b0;
      solved_q     <= &(known_q | ~active_mask);
      if (started) begin
        state_q    <= IDLE;
        rows_q     <= num_rows;
        cols_q     <= num_cols;
        known_q    <= '0;
        assigned_q <= '0;
        solved_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (line_valid) begin
            idx_q   <= line_index;
            rem_q   <= line_opt_cnt;
            keep_q  <= '0;
            and_q   <= '1;
            or_q    <= '0;
            state_q <= (line_opt_cnt == '0) ? COMMIT : COLLECT;
          end
          COLLECT: if (opt_valid) begin
            if (consistent) begin
              and_q <= and_q & option;
              or_q  <= or_q | option;
              if (keep_q != '1) keep_q <= keep_q + CNT_W'(1);
            end
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_q <= COMMIT;
          end
          COMMIT: begin
            state_q      <= IDLE;
            done_valid_q <= 1'b1;
            done_index_q <= idx_q;
            amnt_q       <= keep_q;
            if (keep_q == '0 || !in_range) begin
              conflict_q <= 1'b1;
              put_back_q <= 1'b0;
            end else begin
              conflict_q <= 1'b0;
              put_back_q <= line_open;
              known_q    <= known_d;
              assigned_q <= assigned_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign line_ready       = (state_q == IDLE);
  assign opt_ready        = (state_q == COLLECT);
  assign done_valid       = done_valid_q;
  assign done_index       = done_index_q;
  assign new_options_amnt = amnt_q;
  assign put_back_to_FIFO = put_back_q;
  assign conflict         = conflict_q;
  assign known            = known_q;
  assign assigned         = assigned_q;
  assign solved           = solved_q;
endmodule

// File: tb/tb_line_consensus.sv
// tb/tb_line_consensus.sv - directed and randomized bench for line_consensus against a cell-level reference model
module tb_line_consensus;
  localparam int MS = 11;
  localparam int CW = 7;
  localparam int IW = $clog2(2*MS);
  localparam int DW = $clog2(MS+1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           started = 1'b0;
  logic [DW-1:0]  num_rows = DW'(MS);
  logic [DW-1:0]  num_cols = DW'(MS);
  logic           line_valid = 1'b0;
  logic           line_ready;
  logic [IW-1:0]  line_index = '0;
  logic [CW-1:0]  line_opt_cnt = '0;
  logic           opt_valid = 1'b0;
  logic           opt_ready;
  logic [MS-1:0]  option = '0;
  logic           done_valid;
  logic [IW-1:0]  done_index;
  logic [CW-1:0]  new_options_amnt;
  logic           put_back_to_FIFO;
  logic           conflict;
  logic [MS*MS-1:0] known;
  logic [MS*MS-1:0] assigned;
  logic           solved;

  line_consensus #(.MAX_SIZE(MS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .started(started), .num_rows(num_rows), .num_cols(num_cols),
    .line_valid(line_valid), .line_ready(line_ready), .line_index(line_index),
    .line_opt_cnt(line_opt_cnt), .opt_valid(opt_valid), .opt_ready(opt_ready), .option(option),
    .done_valid(done_valid), .done_index(done_index), .new_options_amnt(new_options_amnt),
    .put_back_to_FIFO(put_back_to_FIFO), .conflict(conflict), .known(known),
    .assigned(assigned), .solved(solved)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit m_known[MS][MS];
  bit m_asg[MS][MS];
  int m_rows = MS;
  int m_cols = MS;
  logic [MS-1:0] oq[$];
  logic [MS-1:0] truth[MS];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] m_known_vec();
    logic [127:0] v = '0;
    for (int r = 0; r < MS; r++) for (int c = 0; c < MS; c++) v[r*MS+c] = m_known[r][c];
    return v;
  endfunction

  function automatic logic [127:0] m_asg_vec();
    logic [127:0] v = '0;
    for (int r = 0; r < MS; r++) for (int c = 0; c < MS; c++) v[r*MS+c] = m_asg[r][c];
    return v;
  endfunction

  function automatic logic [127:0] m_solved();
    for (int r = 0; r < m_rows; r++) for (int c = 0; c < m_cols; c++) if (!m_known[r][c]) return 128'(0);
    return 128'(1);
  endfunction

  task automatic do_start(input int rows, input int cols);
    started = 1'b1;
    num_rows = DW'(rows);
    num_cols = DW'(cols);
    tick();
    started = 1'b0;
    m_rows = rows;
    m_cols = cols;
    for (int r = 0; r < MS; r++) for (int c = 0; c < MS; c++) begin
      m_known[r][c] = 1'b0;
      m_asg[r][c] = 1'b0;
    end
  endtask

  // Header, then every option in oq, then the result cycle; model decided from surviving options.
  task automatic run_line(input int idx);
    int budget, ln, len, ecnt, ones, r, c;
    bit isrow, inr, ok, econf, epb;
    logic [MS-1:0] surv[$];
    budget = 0;
    while (line_ready !== 1'b1 && budget < 20) begin tick(); budget++; end
    check("hdr_ready", 128'(line_ready), 128'(1));
    line_valid = 1'b1;
    line_index = IW'(idx);
    line_opt_cnt = CW'(oq.size());
    tick();
    line_valid = 1'b0;
    foreach (oq[k]) begin
      check("opt_ready", 128'(opt_ready), 128'(1));
      opt_valid = 1'b1;
      option = oq[k];
      tick();
    end
    opt_valid = 1'b0;
    check("no_early_done", 128'(done_valid), 128'(0));

    isrow = idx < m_rows;
    inr = idx < m_rows + m_cols;
    ln = isrow ? idx : idx - m_rows;
    len = isrow ? m_cols : m_rows;
    foreach (oq[k]) begin
      ok = 1'b1;
`ifdef LINE_CONSENSUS_FILTER_EN
      if (inr) for (int p = 0; p < len; p++) begin
        r = isrow ? ln : p;
        c = isrow ? p : ln;
        if (m_known[r][c] && (oq[k][p] != m_asg[r][c])) ok = 1'b0;
      end
`endif
      if (ok) surv.push_back(oq[k]);
    end
    ecnt = surv.size();
    econf = !inr || ecnt == 0;
    epb = 1'b0;
    if (!econf) begin
      for (int p = 0; p < len; p++) begin
        r = isrow ? ln : p;
        c = isrow ? p : ln;
        if (!m_known[r][c]) begin
          ones = 0;
          foreach (surv[k]) if (surv[k][p]) ones++;
          if (ones == ecnt || ones == 0) begin
            m_known[r][c] = 1'b1;
            m_asg[r][c] = (ones == ecnt);
          end else epb = 1'b1;
        end
      end
    end

    tick();
    check("done_valid", 128'(done_valid), 128'(1));
    check("done_ready", 128'(line_ready), 128'(1));
    check("done_index", 128'(done_index), 128'(idx));
    check("amnt", 128'(new_options_amnt), 128'(ecnt));
    check("conflict", 128'(conflict), 128'(econf));
    check("put_back", 128'(put_back_to_FIFO), 128'(epb));
    check("known", 128'(known), m_known_vec());
    check("assigned", 128'(assigned), m_asg_vec());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rows, cols, idx, ln, len, n;
    bit isrow;
    logic [MS-1:0] pat;

    tick(); tick();
    rst = 1'b0;
    check("rst_known", 128'(known), 128'(0));
    check("rst_assigned", 128'(assigned), 128'(0));
    check("rst_solved", 128'(solved), 128'(0));
    check("rst_done_valid", 128'(done_valid), 128'(0));
    check("rst_line_ready", 128'(line_ready), 128'(1));
    check("rst_opt_ready", 128'(opt_ready), 128'(0));
    check("rst_conflict", 128'(conflict), 128'(0));
    check("rst_amnt", 128'(new_options_amnt), 128'(0));

    do_start(4, 4);
    oq.delete(); oq.push_back(11'h3); oq.push_back(11'h6); oq.push_back(11'hC);
    run_line(0);
    check("row0_known", 128'(known[3:0]), 128'(0));
    oq.delete(); oq.push_back(11'hD);
    run_line(3);
    check("row3_known", 128'(known[36:33]), 128'(4'hF));
    check("row3_assigned", 128'(assigned[36:33]), 128'(4'hD));
    oq.delete(); oq.push_back(11'h8); oq.push_back(11'h1); oq.push_back(11'h2);
    run_line(5);
    check("col1_r2_known", 128'(known[2*MS+1]), 128'(1));
`ifdef LINE_CONSENSUS_FILTER_EN
    check("col1_amnt_filtered", 128'(new_options_amnt), 128'(2));
`else
    check("col1_amnt_unfiltered", 128'(new_options_amnt), 128'(3));
`endif
    oq.delete(); oq.push_back(11'h0);
    run_line(7);
`ifdef LINE_CONSENSUS_FILTER_EN
    check("col3_conflict", 128'(conflict), 128'(1));
`endif
    oq.delete();
    run_line(2);
    check("zero_cnt_conflict", 128'(conflict), 128'(1));
    oq.delete(); oq.push_back(11'h1);
    run_line(9);
    check("out_of_range_conflict", 128'(conflict), 128'(1));

    do_start(4, 4);
    truth[0] = 11'h9; truth[1] = 11'h6; truth[2] = 11'hF; truth[3] = 11'h3;
    for (int r = 0; r < 4; r++) begin
      oq.delete(); oq.push_back(truth[r]); oq.push_back(~truth[r] & 11'hF);
      run_line(r);
    end
    for (int c = 0; c < 4; c++) begin
      pat = '0;
      for (int r = 0; r < 4; r++) pat[r] = truth[r][c];
      oq.delete(); oq.push_back(pat);
      run_line(4 + c);
      check("solved_lag", 128'(solved), 128'(0));
      tick();
      check("solved_model", 128'(solved), m_solved());
    end
    check("solved_final", 128'(solved), 128'(1));

    line_valid = 1'b1; line_index = '0; line_opt_cnt = CW'(3);
    tick();
    line_valid = 1'b0;
    opt_valid = 1'b1; option = 11'h3;
    tick();
    opt_valid = 1'b0;
    do_start(4, 4);
    check("abort_known", 128'(known), 128'(0));
    check("abort_solved", 128'(solved), 128'(0));
    check("abort_ready", 128'(line_ready), 128'(1));
    check("abort_done", 128'(done_valid), 128'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_done", 128'(done_valid), 128'(0));
    end

    started = 1'b1; line_valid = 1'b1; line_index = '0; line_opt_cnt = CW'(2);
    tick();
    started = 1'b0; line_valid = 1'b0;
    check("start_priority_ready", 128'(line_ready), 128'(1));
    check("start_priority_opt", 128'(opt_ready), 128'(0));

    for (int it = 0; it < 8; it++) begin
      rows = $urandom_range(1, MS);
      cols = $urandom_range(1, MS);
      do_start(rows, cols);
      for (int r = 0; r < MS; r++) truth[r] = MS'($urandom);
      for (int l = 0; l < 14; l++) begin
        idx = $urandom_range(0, rows + cols);
        isrow = idx < rows;
        ln = isrow ? idx : idx - rows;
        len = isrow ? cols : rows;
        pat = '0;
        if (idx < rows + cols)
          for (int p = 0; p < len; p++) pat[p] = isrow ? truth[ln][p] : truth[p][ln];
        n = $urandom_range(0, 5);
        oq.delete();
        for (int k = 0; k < n; k++)
          oq.push_back(($urandom_range(0, 1) == 1) ? (pat | (MS'($urandom) & ~((MS'(1) << len) - MS'(1))))
                                                  : MS'($urandom));
        run_line(idx);
        tick();
        check("rand_solved", 128'(solved), m_solved());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
